// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle between the display mux (master) and the
// seven-segment scan driver (slave).
interface seg7_scan_driver_if;
    logic [15:0] inData;
    logic        inBlankZero;
    logic        inEnable;
    logic [6:0]  outSeg;
    logic [3:0]  outAnode;
    logic        outFrame;

    modport master (
        output inData, inBlankZero, inEnable,
        input  outSeg, outAnode, outFrame
    );

    modport slave (
        input  inData, inBlankZero, inEnable,
        output outSeg, outAnode, outFrame
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit hex seven-segment driver. The display value is
// snapshotted once per frame so a scan never tears; one digit is lit per
// refresh slot. Segment and anode pins are active-low and registered.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_driver_if.slave   bus
);

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(REFRESH_DIV - 1);

    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]           digit_idx_q, digit_idx_d;
    logic [15:0]          snap_q, snap_d;
    logic [6:0]           seg_q, seg_d;
    logic [3:0]           anode_q, anode_d;
    logic                 frame_q, frame_d;

    logic                 tick;
    logic                 upper_zero;
    logic                 lit;
    logic [3:0]           nibble;

    // Active-low abcdefg pattern for one hex digit.
    function automatic logic [6:0] decode_hex(input logic [3:0] value);
        logic [6:0] pattern;
        unique case (value)
            4'h0: pattern = 7'b0000001;
            4'h1: pattern = 7'b1001111;
            4'h2: pattern = 7'b0010010;
            4'h3: pattern = 7'b0000110;
            4'h4: pattern = 7'b1001100;
            4'h5: pattern = 7'b0100100;
            4'h6: pattern = 7'b0100000;
            4'h7: pattern = 7'b0001111;
            4'h8: pattern = 7'b0000000;
            4'h9: pattern = 7'b0000100;
            4'hA: pattern = 7'b0001000;
            4'hB: pattern = 7'b1100000;
            4'hC: pattern = 7'b0110001;
            4'hD: pattern = 7'b1000010;
            4'hE: pattern = 7'b0110000;
            default: pattern = 7'b0111000;
        endcase
        return pattern;
    endfunction

    // Prescaler, digit sequencing and frame snapshot; digit 3 wrapping to 0
    // is the frame boundary where the mux value is captured.
    always_comb begin
        tick        = (div_cnt_q == DIV_LAST);
        div_cnt_d   = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
        frame_d     = tick && (digit_idx_q == 2'd3);
        digit_idx_d = tick ? digit_idx_q + 2'd1 : digit_idx_q;
        snap_d      = frame_d ? bus.inData : snap_q;
    end

    // Leading-zero test: the current digit is blankable when it and every
    // more significant nibble are zero; digit 0 always stays lit.
    always_comb begin
        upper_zero = 1'b0;
        unique case (digit_idx_q)
            2'd0:    upper_zero = 1'b0;
            2'd1:    upper_zero = (snap_q[15:4] == 12'h000);
            2'd2:    upper_zero = (snap_q[15:8] == 8'h00);
            default: upper_zero = (snap_q[15:12] == 4'h0);
        endcase
    end

    // Pin values for the digit currently selected; enable and blanking act
    // straight into the output registers without being snapshotted.
    always_comb begin
        nibble  = snap_q[{digit_idx_q, 2'b00} +: 4];
        lit     = bus.inEnable && !(bus.inBlankZero && upper_zero);
        anode_d = lit ? ~(4'b0001 << digit_idx_q) : 4'b1111;
        seg_d   = lit ? decode_hex(nibble) : 7'b1111111;
    end

    // State and output registers; reset parks the scan on digit 3 so the
    // first tick is a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            digit_idx_q <= 2'd3;
            snap_q      <= 16'h0000;
            seg_q       <= 7'b1111111;
            anode_q     <= 4'b1111;
            frame_q     <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            snap_q      <= snap_d;
            seg_q       <= seg_d;
            anode_q     <= anode_d;
            frame_q     <= frame_d;
        end
    end

    assign bus.outSeg   = seg_q;
    assign bus.outAnode = anode_q;
    assign bus.outFrame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: a REFRESH_DIV=4 and a REFRESH_DIV=1 build
// share stimulus; both are compared every cycle against a cycle-count model,
// plus slot tables and hand-written corner sequences.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] tb_data;
    logic        tb_blank;
    logic        tb_enable;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver_if bus4();
    seg7_scan_driver_if bus1();

    assign bus4.inData      = tb_data;
    assign bus4.inBlankZero = tb_blank;
    assign bus4.inEnable    = tb_enable;
    assign bus1.inData      = tb_data;
    assign bus1.inBlankZero = tb_blank;
    assign bus1.inEnable    = tb_enable;

    seg7_scan_driver #(.REFRESH_DIV(4), .DIV_WIDTH(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    seg7_scan_driver #(.REFRESH_DIV(1), .DIV_WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference segment patterns (active-low abcdefg).
    function automatic logic [6:0] ref_decode(input int v);
        case (v)
            0: return 7'b0000001;   1: return 7'b1001111;
            2: return 7'b0010010;   3: return 7'b0000110;
            4: return 7'b1001100;   5: return 7'b0100100;
            6: return 7'b0100000;   7: return 7'b0001111;
            8: return 7'b0000000;   9: return 7'b0000100;
            10: return 7'b0001000;  11: return 7'b1100000;
            12: return 7'b0110001;  13: return 7'b1000010;
            14: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [15:0] act,
                                input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the scan position is derived from the number of
    // clock edges since reset, not from a counter state machine.
    int unsigned m_edges [2];
    int unsigned m_div   [2];
    logic [15:0] m_snap  [2];
    logic [3:0]  m_anode [2];
    logic [6:0]  m_seg   [2];
    logic        m_frame [2];
    int unsigned m_digit;
    logic [15:0] m_upper;
    logic        m_tick;
    logic        m_blank;

    initial begin
        m_div[0] = 4;
        m_div[1] = 1;
    end

    // Advance the model one clock edge, or clear it on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_edges[i] = 0;
                m_snap[i]  = 16'h0000;
                m_anode[i] = 4'hF;
                m_seg[i]   = 7'h7F;
                m_frame[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_digit = (3 + m_edges[i] / m_div[i]) % 4;
                m_upper = m_snap[i] >> (4 * m_digit);
                m_blank = tb_blank && (m_digit != 0) && (m_upper == 16'h0);
                if (!tb_enable || m_blank) begin
                    m_anode[i] = 4'hF;
                    m_seg[i]   = 7'h7F;
                end else begin
                    m_anode[i] = 4'hF & ~(4'(1) << m_digit);
                    m_seg[i]   = ref_decode(int'(m_upper & 16'hF));
                end
                m_tick     = (m_edges[i] % m_div[i]) == (m_div[i] - 1);
                m_frame[i] = m_tick && (m_digit == 3);
                if (m_frame[i]) m_snap[i] = tb_data;
                m_edges[i]++;
            end
        end
    end

    // Compare both builds against the model away from the active edge.
    always @(negedge clk) begin
        check_output("m4_anode", 16'(bus4.outAnode), 16'(m_anode[0]));
        check_output("m4_seg",   16'(bus4.outSeg),   16'(m_seg[0]));
        check_output("m4_frame", 16'(bus4.outFrame), 16'(m_frame[0]));
        check_output("m1_anode", 16'(bus1.outAnode), 16'(m_anode[1]));
        check_output("m1_seg",   16'(bus1.outSeg),   16'(m_seg[1]));
        check_output("m1_frame", 16'(bus1.outFrame), 16'(m_frame[1]));
    end

    typedef struct {
        logic [15:0] data;
        logic [3:0]  anode;
        logic [6:0]  seg;
        logic        frame_last;
    } slot_t;

    slot_t slots [9];

    task automatic apply_stimulus(input logic [15:0] data, input logic blank,
                                  input logic enable);
        tb_data   = data;
        tb_blank  = blank;
        tb_enable = enable;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int frames;
        int mask_sel;
        logic [15:0] mask;

        slots[0] = '{16'h1234, 4'b0111, 7'b0000001, 1'b1};
        slots[1] = '{16'h1234, 4'b1110, 7'b1001100, 1'b0};
        slots[2] = '{16'hABCD, 4'b1101, 7'b0000110, 1'b0};
        slots[3] = '{16'hABCD, 4'b1011, 7'b0010010, 1'b0};
        slots[4] = '{16'hABCD, 4'b0111, 7'b1001111, 1'b1};
        slots[5] = '{16'hABCD, 4'b1110, 7'b1000010, 1'b0};
        slots[6] = '{16'hABCD, 4'b1101, 7'b0110001, 1'b0};
        slots[7] = '{16'hABCD, 4'b1011, 7'b1100000, 1'b0};
        slots[8] = '{16'hABCD, 4'b0111, 7'b0001000, 1'b1};

        rst_n = 1'b0;
        apply_stimulus(16'h1234, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check_output("reset_anode", 16'(bus4.outAnode), 16'h000F);
        check_output("reset_seg",   16'(bus4.outSeg),   16'h007F);
        check_output("reset_frame", 16'(bus4.outFrame), 16'h0000);
        rst_n = 1'b1;

        // Ten edges puts the DIV=4 build at digit 1, prescaler 2; reset
        // there asynchronously, between clock edges.
        repeat (10) step();
        #2 rst_n = 1'b0;
        #1;
        check_output("async_anode4", 16'(bus4.outAnode), 16'h000F);
        check_output("async_seg4",   16'(bus4.outSeg),   16'h007F);
        check_output("async_frame4", 16'(bus4.outFrame), 16'h0000);
        check_output("async_anode1", 16'(bus1.outAnode), 16'h000F);
        @(negedge clk);
        rst_n = 1'b1;

        // Slot table from release: 1234 scanned, ABCD applied mid-frame.
        for (int s = 0; s < 9; s++) begin
            tb_data = slots[s].data;
            for (int c = 0; c < 4; c++) begin
                step();
                check_output("tbl_anode", 16'(bus4.outAnode), 16'(slots[s].anode));
                check_output("tbl_seg",   16'(bus4.outSeg),   16'(slots[s].seg));
                check_output("tbl_frame", 16'(bus4.outFrame),
                             16'(slots[s].frame_last && (c == 3)));
                if (s == 0 || (s == 1 && c == 0)) begin
                    if (s * 4 + c + 1 >= 2)
                        check_output("div1_anode", 16'(bus1.outAnode),
                                     16'(4'hF & ~(4'(1) << (s * 4 + c - 1))));
                end
            end
        end

        // Leading-zero blanking, then the all-zero value.
        apply_stimulus(16'h0070, 1'b1, 1'b1);
        repeat (40) step();
        apply_stimulus(16'h0000, 1'b1, 1'b1);
        repeat (40) step();

        // One full frame dark: scanning and frame pulses continue.
        apply_stimulus(16'h5A3C, 1'b0, 1'b0);
        frames = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            check_output("dark_anode", 16'(bus4.outAnode), 16'h000F);
            check_output("dark_seg",   16'(bus4.outSeg),   16'h007F);
            if (bus4.outFrame === 1'b1) frames++;
        end
        check_output("dark_frames", 16'(frames), 16'd1);
        tb_enable = 1'b1;
        step();
        check_output("reenable_lit", 16'($countones(~bus4.outAnode)), 16'd1);

        // Randomised phase: data churns every cycle, controls flip rarely.
        for (int n = 0; n < 800; n++) begin
            mask_sel = $urandom_range(0, 4);
            case (mask_sel)
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            tb_data = 16'($urandom) & mask;
            if ($urandom_range(0, 15) == 0) tb_enable = ~tb_enable;
            if ($urandom_range(0, 31) == 0) tb_blank = ~tb_blank;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
